leaky_relu_stream: RTL
======================

Name: leaky_relu_stream

Overview:
Post-convolution activation stage that sits directly downstream of conv2d. It captures the flat output tensor when conv2d raises done, applies a shift-based leaky ReLU element by element, and streams the results out over a valid/ready handshake. The next layer (or a line buffer) consumes one activation per accepted beat, so the wide flat bus becomes a narrow stream.

Parameters:
NUM_ELEMS, 4, number of tensor elements (BATCH*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH of the upstream conv2d)
DATA_WIDTH, 32, element width, signed two's complement
NEG_SHIFT, 3, negative slope = 2^-NEG_SHIFT (arithmetic right shift)
CLAMP_MAX, 100, positive saturation ceiling; used only when LEAKY_RELU_CLAMP_EN is defined

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in_done  input  1  upstream conv2d done (level; may stay high for many cycles)
in_tensor_flat  input  NUM_ELEMS*DATA_WIDTH  upstream output tensor; element i at [i*DATA_WIDTH +: DATA_WIDTH]
out_data  output  DATA_WIDTH  activated element
out_index  output  $clog2(NUM_ELEMS) (minimum 1)  index of the element on out_data
out_valid  output  1  out_data/out_index valid
out_ready  input  1  consumer accepts the beat
busy  output  1  high in STREAM state
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, rst=1): state=IDLE; out_data=0, out_index=0, out_valid=0, busy=0, done=0; edge-detect register in_done_d=0; capture buffer need not be cleared.
- in_done_d samples in_done every cycle. A start event is in_done=1 and in_done_d=0.
- States: IDLE, STREAM, DONE.
- IDLE: on a start event at posedge T, latch all NUM_ELEMS elements into the internal buffer, load out_data=f(elem0), out_index=0, out_valid=1, busy=1, and move to STREAM. The first beat is therefore visible in the cycle after T (1-cycle latency).
- STREAM: a beat transfers on a posedge with out_valid=1 and out_ready=1. On a transfer with out_index < NUM_ELEMS-1: out_index increments and out_data=f(next element) at that same edge, so there are no bubbles and one element per cycle is sustained while ready stays high. On a transfer with out_index = NUM_ELEMS-1: out_valid=0, busy=0, done=1, and state moves to DONE.
- With out_valid=1 and out_ready=0, out_data and out_index hold stable (AXI-style; valid is never dropped without a transfer).
- DONE: lasts one cycle. done returns to 0 and state returns to IDLE.
- Start events in STREAM or DONE are ignored. A new tensor needs in_done to fall and rise again while in IDLE. If in_done is still high when the block re-enters IDLE, no restart occurs because there is no edge.
- in_tensor_flat changing after capture has no effect on the stream in progress.
- f(x): if x >= 0, x; else x >>> NEG_SHIFT (arithmetic shift, rounds toward -inf). The result keeps DATA_WIDTH bits; the sign is preserved and no overflow is possible.
- Reset asserted mid-stream aborts immediately to the reset values; no done pulse is generated.
- NUM_ELEMS=1: the first accepted beat is also the last, and done pulses on the cycle after it.

Optional Feature:
Macro LEAKY_RELU_CLAMP_EN.
- Defined: positive results are saturated, f(x)=min(x, CLAMP_MAX) for x >= 0 (ReLU-N style). The negative path is unchanged.
- Undefined: no clamp logic is generated, CLAMP_MAX is ignored, and positive values pass through unchanged.

Test Plan:
1. Defaults, out_ready=1. in_tensor elements {84,92,116,124}; raise in_done. Expect out_valid high the cycle after the rise, then beats (0,84),(1,92),(2,116),(3,124) on 4 consecutive cycles, then a single-cycle done pulse. busy is high for exactly 4 cycles.
2. Negative path. Elements {-16,-1,-17,0}. Expect outputs {-2,-1,-3,0}.
3. Backpressure. Hold out_ready=0 for 3 cycles at index 1: out_data=92 and out_index=1 stay stable with out_valid=1. Release: the remaining beats arrive in order and the total number of transfers is 4.
4. Retrigger and level handling. Keep in_done high through the end of the stream and the done pulse: no second stream starts. Drop in_done, raise it again with new data {5,-8,7,-40}: expect {5,-1,7,-5}. A start event raised mid-stream is ignored.
5. Async reset at index 2: all outputs clear without waiting for a clock edge, and no done pulse follows. A fresh start afterwards streams from index 0.
6. With LEAKY_RELU_CLAMP_EN, CLAMP_MAX=100, elements {84,92,116,124}: expect {84,92,100,100}. Without the macro, the same stimulus gives {84,92,116,124}.

Source files
------------

// File: rtl/leaky_relu_stream.sv
// -----------------------------------------------------------------------------
// leaky_relu_stream
//
// Post-convolution activation stage. When the upstream conv2d raises done,
// the whole flat output tensor is captured in one cycle. A shift-based leaky
// ReLU is then applied element by element, and the results are streamed out
// over a valid/ready handshake, one activation per accepted beat.
//
// Activation f(x):
//   x >= 0 : x               (saturated to CLAMP_MAX when LEAKY_RELU_CLAMP_EN)
//   x <  0 : x >>> NEG_SHIFT (arithmetic shift, rounds toward -inf)
//
// Optional feature macro: LEAKY_RELU_CLAMP_EN
//   defined   -> positive results are clamped to CLAMP_MAX (ReLU-N style)
//   undefined -> no clamp logic, CLAMP_MAX is ignored
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-high reset
//   in_done        in   upstream done level; its rising edge starts a capture
//   in_tensor_flat in   flat tensor, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_data       out  activated element
//   out_index      out  index of the element on out_data
//   out_valid      out  out_data/out_index valid
//   out_ready      in   consumer accepts the current beat
//   busy           out  high while streaming
//   done           out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module leaky_relu_stream #(
   parameter int NUM_ELEMS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NEG_SHIFT  = 3,
   parameter int CLAMP_MAX  = 100,
   localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_done,
   input  logic [NUM_ELEMS*DATA_WIDTH-1:0] in_tensor_flat,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [IDX_W-1:0]                out_index,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy,
   output logic                            done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

`ifdef LEAKY_RELU_CLAMP_EN
   localparam logic signed [DATA_WIDTH-1:0] CLAMP_VAL = DATA_WIDTH'(CLAMP_MAX);
`endif

   state_t                 state;
   state_t                 state_next;
   logic                   in_done_d;
   logic                   start;
   logic                   xfer;
   logic                   last_beat;
   logic [IDX_W-1:0]       next_idx;
   logic [DATA_WIDTH-1:0]  buf_mem [NUM_ELEMS];

   // Leaky ReLU on one element; the result always fits in DATA_WIDTH bits.
   function automatic logic [DATA_WIDTH-1:0] act(input logic [DATA_WIDTH-1:0] x);
      logic signed [DATA_WIDTH-1:0] sx;
      sx = signed'(x);
      if (sx[DATA_WIDTH-1])
         act = sx >>> NEG_SHIFT;
`ifdef LEAKY_RELU_CLAMP_EN
      else if (sx > CLAMP_VAL)
         act = CLAMP_VAL;
`endif
      else
         act = x;
   endfunction

   // Only a rising edge of in_done seen in IDLE starts a new tensor, so a
   // level that stays high across the end of a stream cannot retrigger it.
   assign start     = in_done && !in_done_d && (state == IDLE);
   assign xfer      = out_valid && out_ready;
   assign last_beat = (out_index == LAST_IDX);
   assign next_idx  = out_index + IDX_W'(1);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: state_next gets a default before the case so that no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = STREAM;
         STREAM:  if (xfer && last_beat) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode: valid and busy span the whole STREAM state (valid is
   // only dropped by the final transfer), done is the single DONE cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Edge detector and output datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_done_d <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else begin
         in_done_d <= in_done;
         if (start) begin
            // Element 0 comes straight from the bus so the first beat is
            // visible one cycle after the start edge.
            out_data  <= act(in_tensor_flat[DATA_WIDTH-1:0]);
            out_index <= '0;
         end else if (state == STREAM && xfer && !last_beat) begin
            out_data  <= act(buf_mem[next_idx]);
            out_index <= next_idx;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Capture buffer
   // -------------------------------------------------------------------------
   // NOTE: the buffer has no reset; it is always written before it is read,
   // and leaving it out of reset keeps it mappable to plain storage.
   always_ff @(posedge clk) begin
      if (start) begin
         for (int i = 0; i < NUM_ELEMS; i++)
            buf_mem[i] <= in_tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule
